// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: state encoding, opcodes, ALU selects.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD    = 3'd2,
        S_EXECUTE = 3'd3,
        S_STORE   = 3'd4,
        S_HALT    = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    localparam int unsigned OP_STO = 0;
    localparam int unsigned OP_ADD = 1;
    localparam int unsigned OP_SUB = 2;
    localparam int unsigned OP_AND = 3;
    localparam int unsigned OP_OR  = 4;
    localparam int unsigned OP_XOR = 5;
    localparam int unsigned OP_NOT = 6;
    localparam int unsigned OP_JMP = 7;
    localparam int unsigned OP_JZ  = 8;

    localparam logic [2:0] ALU_STO = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_NOT = 3'b110;

    typedef struct packed {
        logic [2:0] s;
        logic       cin;
    } alu_ctl_t;

    // Map an opcode value onto the ALU operation select and carry-in.
    function automatic alu_ctl_t alu_decode(input int unsigned opc);
        alu_ctl_t ctl;
        ctl.s   = ALU_STO;
        ctl.cin = 1'b0;
        case (opc)
            OP_STO: ctl.s = ALU_STO;
            OP_ADD: ctl.s = ALU_ADD;
            OP_SUB: begin
                ctl.s   = ALU_SUB;
                ctl.cin = 1'b1;
            end
            OP_AND: ctl.s = ALU_AND;
            OP_OR:  ctl.s = ALU_OR;
            OP_XOR: ctl.s = ALU_XOR;
            OP_NOT: ctl.s = ALU_NOT;
            default: ctl.s = ALU_STO;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// RAM and ALU control bus between the sequencer (master) and the datapath (slave).
interface ctrl_sequencer_if #(
    parameter int unsigned OPC_W  = 4,
    parameter int unsigned ADDR_W = 4
) ();
    localparam int unsigned INSTR_W = OPC_W + 2 * ADDR_W;

    logic               mem_req;
    logic               mem_we;
    logic               addr_sel;
    logic               data_sel;
    logic [2:0]         alu_s;
    logic               alu_cin;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_ack;
    logic               alu_zero;

    modport master (
        output mem_req, mem_we, addr_sel, data_sel, alu_s, alu_cin,
        input  mem_rdata, mem_ack, alu_zero
    );

    modport slave (
        input  mem_req, mem_we, addr_sel, data_sel, alu_s, alu_cin,
        output mem_rdata, mem_ack, alu_zero
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts RAM wait cycles and flags when the wait budget MEM_TO is spent.
module mem_wait_timer #(
    parameter int unsigned MEM_TO = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic timeout
);
    localparam int unsigned CNT_W = (MEM_TO < 2) ? 1 : $clog2(MEM_TO + 1);

    logic [CNT_W-1:0] r_count;

    // Wait-cycle counter; cleared whenever the access it is timing ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Fires on the wait cycle that reaches MEM_TO so the sequencer leaves on that edge.
    assign timeout = count_en && (r_count == CNT_W'(MEM_TO - 1));
endmodule

// File: rtl/ctrl_sequencer.sv
// Instruction fetch/load/execute/store sequencer driving a RAM and an external ALU.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter  int unsigned OPC_W   = 4,
    parameter  int unsigned ADDR_W  = 4,
    parameter  int unsigned MEM_TO  = 15,
    localparam int unsigned INSTR_W = OPC_W + 2 * ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    ctrl_sequencer_if.master    bus,
    output logic [ADDR_W-1:0]   pc,
    output logic [INSTR_W-1:0]  ir,
    output logic                busy,
    output logic                halted,
    output logic                error,
    output logic                illegal
);
    localparam logic [OPC_W-1:0] OPC_HLT = '1;

    state_t             r_state;
    state_t             w_state_nx;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_nx;
    logic [INSTR_W-1:0] r_ir;
    logic [INSTR_W-1:0] w_ir_nx;
    logic               r_z_flag;
    logic               w_z_flag_nx;
    logic               w_illegal_nx;

    logic [OPC_W-1:0]   w_opc;
    logic [ADDR_W-1:0]  w_op1;
    logic [OPC_W-1:0]   w_rd_opc;

    logic               w_wait_clear;
    logic               w_wait_en;
    logic               w_timeout;

    logic               r_mem_req,  w_mem_req;
    logic               r_mem_we,   w_mem_we;
    logic               r_addr_sel, w_addr_sel;
    logic               r_data_sel, w_data_sel;
    logic [2:0]         r_alu_s,    w_alu_s;
    logic               r_alu_cin,  w_alu_cin;
    logic               r_busy,     w_busy;
    logic               r_halted,   w_halted;
    logic               r_error,    w_error;
    logic               r_illegal;
    alu_ctl_t           w_alu_nx;

    assign w_opc    = r_ir[INSTR_W-1 -: OPC_W];
    assign w_op1    = r_ir[INSTR_W-OPC_W-1 -: ADDR_W];
    assign w_rd_opc = bus.mem_rdata[INSTR_W-1 -: OPC_W];

    // Wait timer runs only while a request is outstanding and restarts per access.
    assign w_wait_en    = r_mem_req && !bus.mem_ack;
    assign w_wait_clear = (w_state_nx != r_state) || bus.mem_ack;

    mem_wait_timer #(
        .MEM_TO   (MEM_TO)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_wait_clear),
        .count_en (w_wait_en),
        .timeout  (w_timeout)
    );

    // State, program counter, instruction and zero-flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_z_flag  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_pc      <= w_pc_nx;
            r_ir      <= w_ir_nx;
            r_z_flag  <= w_z_flag_nx;
        end
    end

    // Next-state, PC, IR and flag update.
    always_comb begin
        w_state_nx   = r_state;
        w_pc_nx      = r_pc;
        w_ir_nx      = r_ir;
        w_z_flag_nx  = r_z_flag;
        w_illegal_nx = 1'b0;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (start) w_state_nx = S_FETCH;
            end
            S_FETCH: begin
                if (bus.mem_ack) begin
                    w_ir_nx = bus.mem_rdata;
                    w_pc_nx = r_pc + ADDR_W'(1);
                    if (w_rd_opc == OPC_HLT) begin
                        w_state_nx = S_HALT;
                    end else if ((w_rd_opc >= OPC_W'(OP_ADD)) && (w_rd_opc <= OPC_W'(OP_NOT))) begin
                        w_state_nx = S_LOAD;
                    end else if ((w_rd_opc == OPC_W'(OP_STO)) || (w_rd_opc == OPC_W'(OP_JMP)) ||
                                 (w_rd_opc == OPC_W'(OP_JZ))) begin
                        w_state_nx = S_EXECUTE;
                    end else begin
                        w_state_nx   = S_FETCH;
                        w_illegal_nx = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nx = S_ERROR;
                end
            end
            S_LOAD: begin
                if (bus.mem_ack)    w_state_nx = S_EXECUTE;
                else if (w_timeout) w_state_nx = S_ERROR;
            end
            S_EXECUTE: begin
                if (w_opc == OPC_W'(OP_JMP)) begin
                    w_pc_nx    = w_op1;
                    w_state_nx = S_FETCH;
                end else if (w_opc == OPC_W'(OP_JZ)) begin
                    if (r_z_flag) w_pc_nx = w_op1;
                    w_state_nx = S_FETCH;
                end else begin
                    w_z_flag_nx = bus.alu_zero;
                    w_state_nx  = S_STORE;
                end
            end
            S_STORE: begin
                if (bus.mem_ack)    w_state_nx = S_FETCH;
                else if (w_timeout) w_state_nx = S_ERROR;
            end
            S_ERROR: begin
                w_state_nx = S_ERROR;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Moore output decode of the upcoming state/IR, registered below.
    // ALU select is held through STORE so the written ALU result stays valid.
    always_comb begin
        w_mem_req  = 1'b0;
        w_mem_we   = 1'b0;
        w_addr_sel = 1'b0;
        w_data_sel = 1'b0;
        w_alu_s    = 3'b000;
        w_alu_cin  = 1'b0;
        w_busy     = 1'b0;
        w_halted   = 1'b0;
        w_error    = 1'b0;
        w_alu_nx   = alu_decode(32'(w_ir_nx[INSTR_W-1 -: OPC_W]));
        case (w_state_nx)
            S_FETCH: begin
                w_mem_req = 1'b1;
                w_busy    = 1'b1;
            end
            S_LOAD: begin
                w_mem_req  = 1'b1;
                w_addr_sel = 1'b1;
                w_busy     = 1'b1;
            end
            S_EXECUTE: begin
                w_alu_s   = w_alu_nx.s;
                w_alu_cin = w_alu_nx.cin;
                w_busy    = 1'b1;
            end
            S_STORE: begin
                w_mem_req  = 1'b1;
                w_mem_we   = 1'b1;
                w_addr_sel = 1'b1;
                w_data_sel = 1'b1;
                w_alu_s    = w_alu_nx.s;
                w_alu_cin  = w_alu_nx.cin;
                w_busy     = 1'b1;
            end
            S_HALT:  w_halted = 1'b1;
            S_ERROR: w_error  = 1'b1;
            default: w_busy   = 1'b0;
        endcase
    end

    // Output registers; reset drops every output immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_addr_sel <= 1'b0;
            r_data_sel <= 1'b0;
            r_alu_s    <= 3'b000;
            r_alu_cin  <= 1'b0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
            r_error    <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_mem_req  <= w_mem_req;
            r_mem_we   <= w_mem_we;
            r_addr_sel <= w_addr_sel;
            r_data_sel <= w_data_sel;
            r_alu_s    <= w_alu_s;
            r_alu_cin  <= w_alu_cin;
            r_busy     <= w_busy;
            r_halted   <= w_halted;
            r_error    <= w_error;
            r_illegal  <= w_illegal_nx;
        end
    end

    assign bus.mem_req  = r_mem_req;
    assign bus.mem_we   = r_mem_we;
    assign bus.addr_sel = r_addr_sel;
    assign bus.data_sel = r_data_sel;
    assign bus.alu_s    = r_alu_s;
    assign bus.alu_cin  = r_alu_cin;
    assign pc           = r_pc;
    assign ir           = r_ir;
    assign busy         = r_busy;
    assign halted       = r_halted;
    assign error        = r_error;
    assign illegal      = r_illegal;
endmodule

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 Parameter OPC_W, default 4, opcode width, SHALL be >= 4.
REQ-002 Parameter ADDR_W, default 4, operand-field, RAM-address and PC width.
REQ-003 Parameter MEM_TO, default 15, max wait cycles for mem_ack before error.
REQ-004 Derived INSTR_W = OPC_W + 2*ADDR_W; fields: opcode [INSTR_W-1 -: OPC_W], op1 next ADDR_W bits, op2 low ADDR_W bits.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  leave IDLE/HALT, begin fetching.
REQ-008 mem_rdata  in  INSTR_W  RAM read data, instruction during FETCH.
REQ-009 mem_ack  in  1  RAM completes current access this cycle.
REQ-010 alu_zero  in  1  ALU result-is-zero flag.
REQ-011 mem_req  out  1  RAM access request (replaces active-low chip select).
REQ-012 mem_we  out  1  1 = write, 0 = read.
REQ-013 addr_sel  out  1  0 = PC, 1 = op1 as RAM address.
REQ-014 data_sel  out  1  0 = op2, 1 = ALU output as RAM write data.
REQ-015 alu_s  out  3  ALU operation select.
REQ-016 alu_cin  out  1  ALU carry-in.
REQ-017 pc  out  ADDR_W  program counter.
REQ-018 ir  out  INSTR_W  instruction register.
REQ-019 busy / halted / error  out  1 each  state flags; illegal  out  1  one-cycle pulse.

Function
REQ-020 States IDLE, FETCH, LOAD, EXECUTE, STORE, HALT, ERROR; outputs Moore-decoded from state and ir.
REQ-021 IDLE: start=1 -> FETCH; else stay.
REQ-022 FETCH: mem_req=1, mem_we=0, addr_sel=0; on mem_ack: ir<=mem_rdata, pc<=pc+1 mod 2^ADDR_W, next state by mem_rdata opcode.
REQ-023 Opcode decode at FETCH ack: 1..6 (ADD,SUB,AND,OR,XOR,NOT) -> LOAD; 0 STO, 7 JMP, 8 JZ -> EXECUTE; 2^OPC_W-1 HLT -> HALT; all others -> FETCH with illegal=1 for one cycle.
REQ-024 LOAD: mem_req=1, mem_we=0, addr_sel=1; on mem_ack -> EXECUTE.
REQ-025 EXECUTE lasts one cycle, mem_req=0; alu_s/alu_cin: STO 000/0, ADD 001/0, SUB 010/1, AND 011/0, OR 100/0, XOR 101/0, NOT 110/0, else 000/0.
REQ-026 EXECUTE, opcodes 0..6: z_flag<=alu_zero; -> STORE.
REQ-027 EXECUTE, JMP: pc<=op1 -> FETCH; JZ: pc<=op1 if z_flag=1, else pc unchanged -> FETCH; z_flag unchanged for both.
REQ-028 STORE: mem_req=1, mem_we=1, addr_sel=1, data_sel=1; on mem_ack -> FETCH.
REQ-029 mem_req SHALL stay high and all other memory outputs stable until the mem_ack cycle inclusive; mem_ack is ignored while mem_req=0; ack in first cycle of a state (zero-wait) is legal.
REQ-030 Wait counter increments each cycle mem_req=1 and mem_ack=0, clears on every state change; reaching MEM_TO -> ERROR.
REQ-031 HALT: halted=1; start=1 -> FETCH resuming at current pc.
REQ-032 ERROR: error=1, mem_req=0; exits only by reset; start ignored.
REQ-033 busy=1 in FETCH, LOAD, EXECUTE, STORE; 0 elsewhere.
REQ-034 PC wrap 2^ADDR_W-1 -> 0 SHALL not flag an error.

Reset
REQ-035 reset=1 SHALL immediately force state IDLE, pc=0, ir=0, z_flag=0, wait counter=0, regardless of clk or any access in progress.
REQ-036 During and after reset all outputs SHALL be 0 (mem_req, mem_we, addr_sel, data_sel, alu_s, alu_cin, busy, halted, error, illegal, pc, ir).

Structure
REQ-037 Shared package ctrl_pkg SHALL hold opcode constants, ALU select codes and state encoding.
REQ-038 Wait counter SHALL be sub-module mem_wait_timer (clk, reset, clear, count_en, timeout; width from MEM_TO).

Verification
REQ-039 Defaults, zero-wait RAM, program {ADD op1=3 op2=0, HLT}, mem[3]=5 -> states FETCH,LOAD,EXECUTE,STORE,FETCH,HALT; alu_s=001 in EXECUTE; pc=2; halted=1.
REQ-040 SUB with mem_ack delayed 3 cycles in LOAD -> mem_req high 4 cycles, addr_sel=1 stable throughout, alu_cin=1 in EXECUTE.
REQ-041 mem_ack never returned in FETCH -> ERROR entered after 15 wait cycles; error=1, mem_req=0; start ignored until reset.
REQ-042 ALU op with alu_zero=1 then JZ op1=9 -> pc=9; repeat with alu_zero=0 -> pc = JZ address + 1.
REQ-043 Opcode 0xA fetched -> illegal=1 exactly one cycle, next state FETCH, pc advanced by 1; pc at 15 fetches -> pc=0.
REQ-044 reset asserted mid-STORE with mem_req=1 -> same-cycle mem_req=0, state IDLE, pc=0; start restarts fetch at address 0.
